// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the duty_shadow_pwm output stage and the
// fade generator feeding it.
//   PWM_INTERVAL_DEFAULT - default clock cycles per PWM period
//   MAX_STEP_DEFAULT     - default per-period duty change limit (slew build)
//   state_t              - shadow register FSM state
//   clamp_duty()         - saturate a requested duty to the period length
//   step_toward()        - move a duty toward a target by a bounded amount
package pwm_pkg;

  localparam int unsigned PWM_INTERVAL_DEFAULT = 1200;
  localparam int unsigned MAX_STEP_DEFAULT     = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  function automatic int unsigned clamp_duty(input int unsigned duty,
                                             input int unsigned limit);
    return (duty > limit) ? limit : duty;
  endfunction

  function automatic int unsigned step_toward(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned lim);
    if (tgt > cur)
      return ((tgt - cur) > lim) ? (cur + lim) : tgt;
    else
      return ((cur - tgt) > lim) ? (cur - lim) : tgt;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running period counter for the PWM stage.
//   clk            - system clock
//   rst_n          - asynchronous active-low reset
//   o_cnt          - position within the period, 0..PWM_INTERVAL-1
//   o_boundary     - high in the last cycle of the period
//   o_period_start - registered boundary, high in every cycle where cnt==0
//                    except the very first one out of reset
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
  parameter int unsigned CNT_W        = $clog2(PWM_INTERVAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_boundary,
  output logic             o_period_start
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_period_start;
  logic             w_boundary;

  assign w_boundary = (r_cnt == CNT_W'(PWM_INTERVAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_boundary ? '0 : (r_cnt + CNT_W'(1));
      r_period_start <= w_boundary;
    end
  end

  assign o_cnt          = r_cnt;
  assign o_boundary     = w_boundary;
  assign o_period_start = r_period_start;

endmodule

// File: rtl/duty_shadow_pwm.sv
// duty_shadow_pwm: PWM output stage with a double-buffered duty register.
// New duty values are accepted over valid/ready into a shadow register and
// only reach the active register on a period boundary, so the waveform never
// changes mid-period.
//   clk            - system clock
//   rst_n          - asynchronous active-low reset
//   i_in_valid     - upstream duty value valid
//   o_in_ready     - stage can accept a duty value (FSM idle)
//   i_in_duty      - requested duty, clock cycles high per period
//   o_pwm_out      - PWM waveform, active high
//   o_period_start - one-cycle pulse in the first cycle of each period
//   o_sat_pulse    - one-cycle pulse after accepting a duty > PWM_INTERVAL
// Build option: define SLEW_LIMIT_EN to limit the active duty change to
// MAX_STEP per period; the FSM stays PENDING until the target is reached.
module duty_shadow_pwm
  import pwm_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
  parameter int unsigned DUTY_W       = $clog2(PWM_INTERVAL + 1),
  parameter int unsigned MAX_STEP     = MAX_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DUTY_W-1:0] i_in_duty,
  output logic              o_pwm_out,
  output logic              o_period_start,
  output logic              o_sat_pulse
);

  localparam int unsigned CNT_W = $clog2(PWM_INTERVAL);
`ifdef SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  // Without slew limiting a full-range step is always allowed, so one
  // boundary always lands exactly on the target.
  localparam int unsigned STEP_LIM = SLEW_EN ? MAX_STEP : PWM_INTERVAL;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DUTY_W-1:0] r_active;
  logic [DUTY_W-1:0] r_shadow;
  logic [DUTY_W-1:0] w_active_nxt;
  logic [DUTY_W-1:0] w_shadow_nxt;
  logic [DUTY_W-1:0] w_clamped;
  logic [DUTY_W-1:0] w_direct;
  logic [DUTY_W-1:0] w_applied;
  logic              r_sat_pulse;
  logic              w_accept;
  logic              w_sat;
  logic              w_boundary;
  logic [CNT_W-1:0]  w_cnt;

  pwm_period_counter #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_counter (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_cnt          (w_cnt),
    .o_boundary     (w_boundary),
    .o_period_start (o_period_start)
  );

  assign o_in_ready = (r_state == IDLE);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_sat      = (32'(i_in_duty) > PWM_INTERVAL);
  assign w_clamped  = DUTY_W'(clamp_duty(32'(i_in_duty), PWM_INTERVAL));
  // Candidate next active values for a direct boundary accept and for
  // applying the pending shadow value.
  assign w_direct   = DUTY_W'(step_toward(32'(r_active), 32'(w_clamped), STEP_LIM));
  assign w_applied  = DUTY_W'(step_toward(32'(r_active), 32'(r_shadow), STEP_LIM));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_active    <= '0;
      r_shadow    <= '0;
      r_sat_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_shadow    <= w_shadow_nxt;
      r_sat_pulse <= w_accept && w_sat;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_shadow_nxt = r_shadow;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_boundary) begin
            w_active_nxt = w_direct;
            // A direct accept too far from active keeps slewing from shadow.
            if (w_direct != w_clamped) begin
              w_shadow_nxt = w_clamped;
              w_state_nxt  = PENDING;
            end
          end else begin
            w_shadow_nxt = w_clamped;
            w_state_nxt  = PENDING;
          end
        end
      end
      PENDING: begin
        if (w_boundary) begin
          w_active_nxt = w_applied;
          if (w_applied == r_shadow)
            w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_pwm_out   = (DUTY_W'(w_cnt) < r_active);
  assign o_sat_pulse = r_sat_pulse;

endmodule

// File: tb/tb_duty_shadow_pwm.sv
// tb_duty_shadow_pwm: directed bench for duty_shadow_pwm with a 16-cycle
// period. Inputs change and outputs are sampled on the falling clock edge.
module tb_duty_shadow_pwm;

  localparam int PI = 16;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_duty = '0;
  logic          in_ready;
  logic          pwm_out;
  logic          period_start;
  logic          sat_pulse;

  int n_err = 0;
  int n_chk = 0;
  int tb_cnt;

  duty_shadow_pwm #(
    .PWM_INTERVAL (PI),
    .DUTY_W       (DW),
    .MAX_STEP     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_duty      (in_duty),
    .o_pwm_out      (pwm_out),
    .o_period_start (period_start),
    .o_sat_pulse    (sat_pulse)
  );

  always #5 clk = ~clk;

  // Reference time base: position within the period since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == PI - 1) ? 0 : tb_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cnt=%0d)", tag, obs, exp, tb_cnt);
    end
  endtask

  task automatic wait_cnt(input int k);
    int n;
    n = 0;
    while (tb_cnt != k && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_cnt", 32'(tb_cnt), 32'(k));
  endtask

  initial begin
    int hi;
    repeat (3) @(negedge clk);
    chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_pstart", {31'd0, period_start}, 32'd0);
    chk("rst_sat", {31'd0, sat_pulse}, 32'd0);
    rst_n = 1'b1;

`ifdef SLEW_LIMIT_EN
    wait_cnt(5);
    in_valid = 1'b1; in_duty = 5'd8;
    @(negedge clk);
    in_valid = 1'b0; in_duty = 5'd0;
    chk("slew_ready_pend", {31'd0, in_ready}, 32'd0);
    wait_cnt(0);
    for (int p = 1; p <= 4; p++) begin
      chk("slew_ready", {31'd0, in_ready}, (p == 4) ? 32'd1 : 32'd0);
      hi = 0;
      for (int i = 0; i < PI; i++) begin
        hi += int'(pwm_out);
        @(negedge clk);
      end
      chk("slew_high_cycles", 32'(hi), 32'(2 * p));
    end
`else
    // Idle after reset: low output, ready, period_start only at later cnt==0.
    for (int n = 0; n < 34; n++) begin
      chk("idle_pwm", {31'd0, pwm_out}, 32'd0);
      chk("idle_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_pstart", {31'd0, period_start},
          (tb_cnt == 0 && n != 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Duty 4 accepted at cnt=5.
    wait_cnt(5);
    in_valid = 1'b1; in_duty = 5'd4;
    @(negedge clk);
    in_valid = 1'b0; in_duty = 5'd31;
    chk("d4_sat", {31'd0, sat_pulse}, 32'd0);
    for (int k = 6; k < PI; k++) begin
      chk("d4_ready_low", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("d4_ready_back", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < PI; i++) begin
      chk("d4_pwm", {31'd0, pwm_out}, (tb_cnt < 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Duty 20 saturates to a full period.
    wait_cnt(3);
    in_valid = 1'b1; in_duty = 5'd20;
    @(negedge clk);
    in_valid = 1'b0; in_duty = 5'd0;
    chk("d20_sat_pulse", {31'd0, sat_pulse}, 32'd1);
    @(negedge clk);
    chk("d20_sat_clear", {31'd0, sat_pulse}, 32'd0);
    chk("d20_ready_low", {31'd0, in_ready}, 32'd0);
    wait_cnt(0);
    for (int i = 0; i < PI; i++) begin
      chk("d20_pwm", {31'd0, pwm_out}, 32'd1);
      @(negedge clk);
    end

    // Duty 8 accepted exactly on the boundary cycle.
    wait_cnt(15);
    chk("d8_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_duty = 5'd8;
    @(negedge clk);
    in_valid = 1'b0; in_duty = 5'd1;
    chk("d8_ready_post", {31'd0, in_ready}, 32'd1);
    chk("d8_sat", {31'd0, sat_pulse}, 32'd0);
    for (int i = 0; i < PI; i++) begin
      chk("d8_pwm", {31'd0, pwm_out}, (tb_cnt < 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Duty 10 pending, reset at cnt=9 discards it.
    wait_cnt(3);
    in_valid = 1'b1; in_duty = 5'd10;
    @(negedge clk);
    in_valid = 1'b0; in_duty = 5'd0;
    wait_cnt(9);
    chk("d10_ready_pend", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pwm", {31'd0, pwm_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_pstart", {31'd0, period_start}, 32'd0);
    chk("mid_rst_sat", {31'd0, sat_pulse}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      chk("post_rst_pwm", {31'd0, pwm_out}, 32'd0);
      chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_pstart", {31'd0, period_start},
          (tb_cnt == 0 && n != 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (errors=%0d)", n_err);
    $fatal(1, "timeout");
  end

endmodule
